dense_layer_seq: RTL and testbench
==================================

Name: dense_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected layer for the quantised ECG network.
- One signed MAC is shared across all output neurons.
- Weights and biases are streamed from an external synchronous parameter memory; input activations are captured once per start.
- Per-neuron results go into an output register bank, and a one-cycle done pulse fires when the whole layer is finished. Adds a start/busy handshake, bias, fixed-point rescale, optional ReLU and saturation.

Parameters:
- N_IN, 15, number of input activations per neuron
- N_OUT, 30, number of output neurons
- DW, 8, signed activation/weight/bias width
- ACC_W, 32, accumulator width; must be >= 2*DW+clog2(N_IN)+FRAC+1
- FRAC, 7, fractional bits of weights; result is arithmetically shifted right by FRAC
- RELU, 1, 1 = clamp negative results to 0; 0 = linear
- MEM_AW, 9, parameter memory address width; must satisfy 2^MEM_AW >= N_OUT*(N_IN+1)

Ports:
- clk  input  1  clock; all logic on posedge
- reset  input  1  synchronous, active-high
- start  input  1  request layer evaluation; honoured only in IDLE
- in_vec  input  N_IN*DW  signed activations; element i at [i*DW +: DW]
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- out_valid  output  1  single-cycle pulse: all N_OUT results are written
- out_vec  output  N_OUT*DW  signed results; neuron n at [n*DW +: DW]
- mem_rd  output  1  parameter memory read enable
- mem_addr  output  MEM_AW  parameter memory address
- mem_data  input  DW  parameter word; valid exactly 1 cycle after mem_rd/mem_addr

Behaviour:
- Reset values: busy=0, out_valid=0, mem_rd=0, mem_addr=0, out_vec all zero. Internal state: acc=0, n=0, k=0, state=IDLE.
- Memory layout: neuron n occupies words n*(N_IN+1) .. n*(N_IN+1)+N_IN.
  - Offsets 0..N_IN-1 are weights for in[0..N_IN-1].
  - Offset N_IN is the bias, scaled with the same FRAC as the products.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches in_vec into an internal register.
  - Clears acc, n and k; next state is RUN.
  - start=0: stay in IDLE.
- RUN: k counts 0..N_IN+1 for each neuron n.
  - k in 0..N_IN: mem_rd=1, mem_addr=n*(N_IN+1)+k. Otherwise mem_rd=0 and mem_addr holds its last value.
  - k in 1..N_IN: acc <= acc + sext(in[k-1]) * sext(mem_data), full signed product, ACC_W-bit wrap arithmetic. Parameter constraints guarantee no overflow.
  - k = N_IN+1 (mem_data = bias):
    - s = (acc + (sext(bias) <<< FRAC)) >>> FRAC (floor, no rounding).
    - If RELU=1 and s<0, then s=0.
    - Saturate s to [-2^(DW-1), 2^(DW-1)-1].
    - Write s to out_vec slot n; clear acc; k=0.
    - If n=N_OUT-1, next state is DONE; else n=n+1.
- DONE: out_valid=1 for exactly this cycle, busy=1, then return to IDLE.
- Timing: start is sampled at cycle 0.
  - Neuron n spans cycles 1+n*(N_IN+2) .. (n+1)*(N_IN+2).
  - out_valid is high at cycle N_OUT*(N_IN+2)+1 (511 with defaults).
  - The next start is accepted at the cycle after out_valid at the earliest.
- out_vec slots update progressively as each neuron finishes. All slots are stable from out_valid until the matching slot is rewritten by the next run.
- start in RUN or DONE is ignored; it is neither queued nor causes a restart.
- in_vec changes after acceptance have no effect on the current run.
- reset asserted mid-run aborts immediately:
  - All outputs return to their reset values, including out_vec cleared.
  - out_valid is not produced.
  - Next state is IDLE.
- reset and start in the same cycle: reset wins.

Test Plan:
- Defaults; all in=2, all weights=64 (0.5), biases=0 -> every out slot = 15 (0x0F); out_valid high exactly at cycle 511 after start, one cycle only; busy low at cycle 512.
- All in=127, weights=127, bias=0 -> acc=241935, shifted=1890 -> every slot saturates to 127 (0x7F).
- Weights=-64, in=2, bias=0: RELU=1 -> all slots 0. RELU=0 -> all slots -15 (0xF1). Also with RELU=0, in=-128, weights=127 -> slots saturate to -128 (0x80).
- Weights=0; bias word for neuron 0 = 5, for neuron 29 = -3; RELU=0 -> slot0=5, slot29=-3 (0xFD), others 0.
- Address trace: mem_addr sequence 0..15 for neuron 0, 16..31 for neuron 1, ... 464..479 for neuron 29; mem_rd low during each neuron's k=16 cycle.
- Pulse start again at cycle 50 while busy -> ignored, and exactly one out_valid is seen. Then reset at cycle 100 -> busy=0, out_vec=0, no out_valid. A new start then completes normally with correct results 511 cycles later.

Source files
------------

// File: rtl/dense_layer_seq_if.sv
// Control, activation, result and parameter-memory bundle of the sequential dense layer.
// Latency: none, wires only.
// Backpressure: none; start/busy handshake, memory data returns one cycle after the read.
interface dense_layer_seq_if #(
    parameter int N_IN   = 15,
    parameter int N_OUT  = 30,
    parameter int DW     = 8,
    parameter int MEM_AW = 9
);
    logic                   start;
    logic [N_IN*DW-1:0]     in_vec;
    logic                   busy;
    logic                   out_valid;
    logic [N_OUT*DW-1:0]    out_vec;
    logic                   mem_rd;
    logic [MEM_AW-1:0]      mem_addr;
    logic [DW-1:0]          mem_data;

    modport master (
        output start, in_vec, mem_data,
        input  busy, out_valid, out_vec, mem_rd, mem_addr
    );

    modport slave (
        input  start, in_vec, mem_data,
        output busy, out_valid, out_vec, mem_rd, mem_addr
    );
endinterface

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed MAC shared by all neurons, bias, rescale, ReLU, saturation.
// Latency: N_OUT*(N_IN+2)+1 cycles from accepted start to the out_valid pulse.
// Backpressure: start is honoured only while idle; requests during a run are dropped, not queued.
module dense_layer_seq #(
    parameter int N_IN   = 15,
    parameter int N_OUT  = 30,
    parameter int DW     = 8,
    parameter int ACC_W  = 32,
    parameter int FRAC   = 7,
    parameter int RELU   = 1,
    parameter int MEM_AW = 9
) (
    input  logic              clk,
    input  logic              reset,
    dense_layer_seq_if.slave  bus
);
    localparam int KW = $clog2(N_IN + 2);
    localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [KW-1:0]            K_LAST_RD = KW'(N_IN);
    localparam logic [KW-1:0]            K_BIAS    = KW'(N_IN + 1);
    localparam logic [NW-1:0]            N_LAST    = NW'(N_OUT - 1);
    localparam logic [MEM_AW-1:0]        ADDR_STEP = MEM_AW'(N_IN + 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX   = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [NW-1:0]             n_q, n_d;
    logic [MEM_AW-1:0]         base_q, base_d;
    logic [MEM_AW-1:0]         addr_q, addr_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [N_IN*DW-1:0]        in_sh_q, in_sh_d;
    logic [N_OUT*DW-1:0]       out_q, out_d;

    logic                      rd_c;
    logic [MEM_AW-1:0]         addr_c;

    // The captured activations rotate by one element per MAC, so the current
    // activation is always the low slot and a full neuron restores the order.
    logic signed [DW-1:0]      act;
    logic signed [DW-1:0]      wgt;
    logic signed [2*DW-1:0]    prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   biased;
    logic signed [ACC_W-1:0]   scaled;
    logic signed [ACC_W-1:0]   clamped;
    logic [DW-1:0]             res;

    assign act      = in_sh_q[DW-1:0];
    assign wgt      = bus.mem_data;
    assign prod     = act * wgt;
    assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    assign bias_ext = {{(ACC_W-DW){wgt[DW-1]}}, wgt} <<< FRAC;
    assign biased   = acc_q + bias_ext;
    assign scaled   = biased >>> FRAC;

    // Optional ReLU followed by saturation to the signed DW-bit range.
    always_comb begin
        clamped = scaled;
        res     = scaled[DW-1:0];
        if ((RELU != 0) && (scaled < 0)) begin
            clamped = '0;
        end
        if (clamped > SAT_MAX) begin
            res = SAT_MAX[DW-1:0];
        end else if (clamped < SAT_MIN) begin
            res = SAT_MIN[DW-1:0];
        end else begin
            res = clamped[DW-1:0];
        end
    end

    // Next-state, memory request and datapath updates for the sequencer.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        base_d  = base_q;
        acc_d   = acc_q;
        in_sh_d = in_sh_q;
        out_d   = out_q;
        rd_c    = 1'b0;
        addr_c  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    in_sh_d = bus.in_vec;
                    acc_d   = '0;
                    n_d     = '0;
                    k_d     = '0;
                    base_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (k_q <= K_LAST_RD) begin
                    rd_c   = 1'b1;
                    addr_c = base_q + MEM_AW'(k_q);
                end
                if (k_q == K_BIAS) begin
                    out_d[n_q*DW +: DW] = res;
                    acc_d  = '0;
                    k_d    = '0;
                    base_d = base_q + ADDR_STEP;
                    if (n_q == N_LAST) begin
                        state_d = DONE;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end else begin
                    if (k_q != '0) begin
                        acc_d   = acc_q + prod_ext;
                        in_sh_d = {in_sh_q[DW-1:0], in_sh_q[N_IN*DW-1:DW]};
                    end
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        addr_d = addr_c;
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            in_sh_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            in_sh_q <= in_sh_d;
            out_q   <= out_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_vec   = out_q;
    assign bus.mem_rd    = rd_c;
    assign bus.mem_addr  = addr_c;
endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: a ReLU and a linear instance run in lockstep against a behavioural layer model.
// Latency: expects out_valid exactly N_OUT*(N_IN+2)+1 cycles after start.
// Backpressure: none; synchronous parameter memory model answers every read one cycle later.
module tb_dense_layer_seq;
    localparam int N_IN   = 15;
    localparam int N_OUT  = 30;
    localparam int DW     = 8;
    localparam int ACC_W  = 32;
    localparam int FRAC   = 7;
    localparam int MEM_AW = 9;
    localparam int SPAN   = N_IN + 2;
    localparam int T_DONE = N_OUT * SPAN + 1;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [N_IN*DW-1:0] in_vec;
    logic signed [DW-1:0] mem [2**MEM_AW];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dense_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .MEM_AW(MEM_AW)) bus_r ();
    dense_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .MEM_AW(MEM_AW)) bus_l ();

    assign bus_r.start  = start;
    assign bus_l.start  = start;
    assign bus_r.in_vec = in_vec;
    assign bus_l.in_vec = in_vec;

    dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W), .FRAC(FRAC),
                      .RELU(1), .MEM_AW(MEM_AW)) u_relu (.clk(clk), .reset(reset), .bus(bus_r));
    dense_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(ACC_W), .FRAC(FRAC),
                      .RELU(0), .MEM_AW(MEM_AW)) u_lin  (.clk(clk), .reset(reset), .bus(bus_l));

    // Synchronous parameter memories, one read port per instance.
    always @(posedge clk) begin
        if (bus_r.mem_rd) bus_r.mem_data <= mem[bus_r.mem_addr];
        if (bus_l.mem_rd) bus_l.mem_data <= mem[bus_l.mem_addr];
    end

    // Reference layer computed directly from the arithmetic definition.
    function automatic logic [N_OUT*DW-1:0] model(input logic [N_IN*DW-1:0] inv, input bit relu);
        logic [N_OUT*DW-1:0] r;
        longint acc;
        longint s;
        r = '0;
        for (int n = 0; n < N_OUT; n++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                acc += longint'($signed(inv[i*DW +: DW])) * longint'(mem[n*(N_IN+1) + i]);
            s = (acc + longint'(mem[n*(N_IN+1) + N_IN]) * (longint'(1) <<< FRAC)) >>> FRAC;
            if (relu && s < 0) s = 0;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            r[n*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [N_IN*DW-1:0] fill_in(input int v);
        logic [N_IN*DW-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    function automatic logic [N_IN*DW-1:0] rand_in();
        logic [N_IN*DW-1:0] r;
        for (int i = 0; i < N_IN; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic set_mem(input int w, input int b);
        for (int a = 0; a < 2**MEM_AW; a++) mem[a] = '0;
        for (int n = 0; n < N_OUT; n++) begin
            for (int i = 0; i < N_IN; i++) mem[n*(N_IN+1) + i] = DW'(w);
            mem[n*(N_IN+1) + N_IN] = DW'(b);
        end
    endtask

    task automatic rand_mem();
        for (int a = 0; a < 2**MEM_AW; a++) mem[a] = DW'($urandom);
    endtask

    // One full evaluation, starting at a falling edge; returns at the falling edge of cycle T_DONE+1.
    task automatic run_layer(input logic [N_IN*DW-1:0] inv, input int pulse_at, input string tag);
        logic [N_OUT*DW-1:0] exp_r, exp_l, snap_r, snap_l;
        int ov_r, ov_l, ov_cyc, busy_err, trace_err, n, k, exp_addr;
        logic exp_busy, exp_rd;
        exp_r = model(inv, 1'b1);
        exp_l = model(inv, 1'b0);
        ov_r = 0; ov_l = 0; ov_cyc = -1; busy_err = 0; trace_err = 0;
        snap_r = '0; snap_l = '0;
        start  = 1'b1;
        in_vec = inv;
        @(posedge clk);
        for (int c = 1; c <= T_DONE + 1; c++) begin
            @(negedge clk);
            if (bus_r.out_valid === 1'b1) begin ov_r++; ov_cyc = c; end
            if (bus_l.out_valid === 1'b1) ov_l++;
            exp_busy = (c <= T_DONE);
            if (bus_r.busy !== exp_busy || bus_l.busy !== exp_busy) busy_err++;
            if (c < T_DONE) begin
                n = (c - 1) / SPAN;
                k = (c - 1) % SPAN;
                exp_rd   = (k <= N_IN);
                exp_addr = n*(N_IN+1) + ((k <= N_IN) ? k : N_IN);
                if (bus_r.mem_rd !== exp_rd || bus_l.mem_rd !== exp_rd ||
                    bus_r.mem_addr !== MEM_AW'(exp_addr) || bus_l.mem_addr !== MEM_AW'(exp_addr))
                    trace_err++;
            end
            if (c == T_DONE) begin snap_r = bus_r.out_vec; snap_l = bus_l.out_vec; end
            start  = (c == pulse_at);
            in_vec = rand_in();
        end
        n_vec++; if (ov_r !== 1) begin n_err++; $display("FAIL %s ov_count_relu: got %0d want 1", tag, ov_r); end
        n_vec++; if (ov_l !== 1) begin n_err++; $display("FAIL %s ov_count_lin: got %0d want 1", tag, ov_l); end
        n_vec++; if (ov_cyc !== T_DONE) begin n_err++; $display("FAIL %s ov_cycle: got %0d want %0d", tag, ov_cyc, T_DONE); end
        n_vec++; if (busy_err !== 0) begin n_err++; $display("FAIL %s busy_profile: got %0d bad cycles want 0", tag, busy_err); end
        n_vec++; if (trace_err !== 0) begin n_err++; $display("FAIL %s addr_trace: got %0d bad cycles want 0", tag, trace_err); end
        n_vec++; if (snap_r !== exp_r) begin n_err++; $display("FAIL %s out_relu: got %h want %h", tag, snap_r, exp_r); end
        n_vec++; if (snap_l !== exp_l) begin n_err++; $display("FAIL %s out_lin: got %h want %h", tag, snap_l, exp_l); end
        n_vec++; if (bus_r.out_vec !== exp_r || bus_l.out_vec !== exp_l) begin
            n_err++; $display("FAIL %s out_stable: got %h/%h want %h/%h", tag, bus_r.out_vec, bus_l.out_vec, exp_r, exp_l);
        end
    endtask

    task automatic test_reset();
        n_vec++; if (bus_r.busy !== 1'b0 || bus_l.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b/%b want 0", bus_r.busy, bus_l.busy); end
        n_vec++; if (bus_r.out_valid !== 1'b0 || bus_l.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b/%b want 0", bus_r.out_valid, bus_l.out_valid); end
        n_vec++; if (bus_r.mem_rd !== 1'b0 || bus_r.mem_addr !== '0) begin n_err++; $display("FAIL reset_mem: got rd=%b addr=%0d want 0/0", bus_r.mem_rd, bus_r.mem_addr); end
        n_vec++; if (bus_r.out_vec !== '0 || bus_l.out_vec !== '0) begin n_err++; $display("FAIL reset_out_vec: got %h want 0", bus_r.out_vec); end
        // reset and start together: reset must win
        start = 1'b1;
        @(negedge clk);
        n_vec++; if (bus_r.busy !== 1'b0) begin n_err++; $display("FAIL reset_beats_start: got busy=%b want 0", bus_r.busy); end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_half();
        set_mem(64, 0);
        run_layer(fill_in(2), -1, "half");
        n_vec++; if (bus_l.out_vec !== {N_OUT{8'h0F}}) begin n_err++; $display("FAIL half_const: got %h want all 0F", bus_l.out_vec); end
    endtask

    task automatic test_saturate_pos();
        set_mem(127, 0);
        run_layer(fill_in(127), -1, "sat_pos");
        n_vec++; if (bus_r.out_vec !== {N_OUT{8'h7F}}) begin n_err++; $display("FAIL sat_pos_const: got %h want all 7F", bus_r.out_vec); end
    endtask

    task automatic test_negative();
        set_mem(-64, 0);
        run_layer(fill_in(2), -1, "negative");
        n_vec++; if (bus_r.out_vec !== '0) begin n_err++; $display("FAIL relu_const: got %h want 0", bus_r.out_vec); end
        n_vec++; if (bus_l.out_vec !== {N_OUT{8'hF1}}) begin n_err++; $display("FAIL linear_neg_const: got %h want all F1", bus_l.out_vec); end
        set_mem(127, 0);
        run_layer(fill_in(-128), -1, "sat_neg");
        n_vec++; if (bus_l.out_vec !== {N_OUT{8'h80}}) begin n_err++; $display("FAIL sat_neg_const: got %h want all 80", bus_l.out_vec); end
    endtask

    task automatic test_bias();
        logic [N_OUT*DW-1:0] want;
        set_mem(0, 0);
        mem[N_IN] = 8'sd5;
        mem[(N_OUT-1)*(N_IN+1) + N_IN] = -8'sd3;
        run_layer(rand_in(), -1, "bias");
        want = '0;
        want[DW-1:0] = 8'h05;
        want[(N_OUT-1)*DW +: DW] = 8'hFD;
        n_vec++; if (bus_l.out_vec !== want) begin n_err++; $display("FAIL bias_const: got %h want %h", bus_l.out_vec, want); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            rand_mem();
            run_layer(rand_in(), -1, "random");
        end
    endtask

    task automatic test_back_to_back();
        rand_mem();
        run_layer(rand_in(), 50, "ignored_start");
        run_layer(rand_in(), -1, "back_to_back");
    endtask

    task automatic test_abort();
        int ov;
        ov = 0;
        rand_mem();
        start  = 1'b1;
        in_vec = rand_in();
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus_r.out_valid === 1'b1 || bus_l.out_valid === 1'b1) ov++;
            start = (c == 50);
            reset = (c == 100);
        end
        @(negedge clk);
        reset = 1'b0;
        n_vec++; if (bus_r.busy !== 1'b0 || bus_l.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b/%b want 0", bus_r.busy, bus_l.busy); end
        n_vec++; if (bus_r.out_vec !== '0 || bus_l.out_vec !== '0) begin n_err++; $display("FAIL abort_out_vec: got %h want 0", bus_l.out_vec); end
        n_vec++; if (bus_l.mem_rd !== 1'b0 || bus_l.mem_addr !== '0) begin n_err++; $display("FAIL abort_mem: got rd=%b addr=%0d want 0/0", bus_l.mem_rd, bus_l.mem_addr); end
        for (int c = 102; c <= T_DONE + 40; c++) begin
            @(negedge clk);
            if (bus_r.out_valid === 1'b1 || bus_l.out_valid === 1'b1) ov++;
        end
        n_vec++; if (ov !== 0) begin n_err++; $display("FAIL abort_no_valid: got %0d pulses want 0", ov); end
        rand_mem();
        run_layer(rand_in(), -1, "after_abort");
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        in_vec = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_half();
        test_saturate_pos();
        test_negative();
        test_bias();
        test_random();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
